// File: rtl/ip_req_scheduler.sv
// Round-robin scheduler sharing one pipelined 3-element inner-product datapath
// between NREQ requesters, with per-requester result holding and valid/ready return.
module ip_req_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*9-1:0] req_a,
    input  logic [NREQ*9-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [NREQ*8-1:0] resp_data,
    output logic [8:0]        dp_inp1,
    output logic [8:0]        dp_inp2,
    input  logic [7:0]        dp_outp,
    output logic              busy
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR      = NREQ;
    localparam logic [PW-1:0] LAST_ID = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        DONE     = 2'd2
    } slot_t;

    slot_t         slot [NREQ];
    logic [PW-1:0] rr_ptr;
    logic          iss_v;
    logic [PW-1:0] iss_id;
    logic [LAT-1:0] tag_v;
    logic [PW-1:0] tag_id [LAT];

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [PW-1:0]   gnt_id;
    int unsigned     scan_idx;
    logic [8:0]      a_sel;
    logic [8:0]      b_sel;

    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            eligible[i] = req_valid[i] && (slot[i] == IDLE);
        end
    end

    // Rotating priority: first eligible index at or above rr_ptr, wrapping.
    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_idx = 0;
        for (int unsigned off = 0; off < NR; off++) begin
            scan_idx = 32'(rr_ptr) + off;
            if (scan_idx >= NR) begin
                scan_idx = scan_idx - NR;
            end
            if (!gnt_any && eligible[scan_idx[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_idx[PW-1:0];
            end
        end
        if (gnt_any) begin
            grant[gnt_id] = 1'b1;
        end
    end

    assign req_ready = grant & {NREQ{rst_n}};

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant[i]) begin
                a_sel = req_a[9*i +: 9];
                b_sel = req_b[9*i +: 9];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (slot[i] != IDLE) begin
                busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NR; i++) begin
                slot[i] <= IDLE;
            end
            for (int unsigned s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
            rr_ptr     <= '0;
            iss_v      <= 1'b0;
            iss_id     <= '0;
            tag_v      <= '0;
            dp_inp1    <= '0;
            dp_inp2    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            iss_v   <= gnt_any;
            iss_id  <= gnt_id;
            dp_inp1 <= a_sel;
            dp_inp2 <= b_sel;
            if (gnt_any) begin
                rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end

            // Tag pipe tracks the free-running datapath stage for stage.
            tag_v[0]  <= iss_v;
            tag_id[0] <= iss_id;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end

            for (int unsigned i = 0; i < NR; i++) begin
                case (slot[i])
                    IDLE: begin
                        if (grant[i]) begin
                            slot[i] <= INFLIGHT;
                        end
                    end
                    INFLIGHT: begin
                        if (tag_v[LAT-1] && (tag_id[LAT-1] == PW'(i))) begin
                            slot[i]           <= DONE;
                            resp_valid[i]     <= 1'b1;
                            resp_data[8*i +: 8] <= dp_outp;
                        end
                    end
                    DONE: begin
                        if (resp_ready[i]) begin
                            slot[i]       <= IDLE;
                            resp_valid[i] <= 1'b0;
                        end
                    end
                    default: slot[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ip_req_scheduler.sv
// Bench for ip_req_scheduler: LAT=2 and LAT=3 instances, each driving a behavioural
// datapath; directed scenarios plus a randomized run against a timing-level model.
module tb_ip_req_scheduler;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*9-1:0] req_a, req_b;
    logic [N*8-1:0] resp_data;
    logic [8:0]     dp_inp1, dp_inp2;
    logic [7:0]     dp_outp;
    logic           busy;

    logic [N-1:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [N*9-1:0] b_req_a, b_req_b;
    logic [N*8-1:0] b_resp_data;
    logic [8:0]     b_dp_inp1, b_dp_inp2;
    logic [7:0]     b_dp_outp;
    logic           b_busy;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] ip(input logic [8:0] a, input logic [8:0] b);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            s += int'(a[3*k +: 3]) * int'(b[3*k +: 3]);
        end
        return 8'(s);
    endfunction

    ip_req_scheduler #(.NREQ(N), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .dp_inp1(dp_inp1), .dp_inp2(dp_inp2), .dp_outp(dp_outp),
        .busy(busy)
    );

    ip_req_scheduler #(.NREQ(N), .LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_a(b_req_a), .req_b(b_req_b),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .dp_inp1(b_dp_inp1), .dp_inp2(b_dp_inp2), .dp_outp(b_dp_outp),
        .busy(b_busy)
    );

    logic [7:0] dpa [2];
    logic [7:0] dpb [3];
    always @(posedge clk) begin
        dpa[0] <= ip(dp_inp1, dp_inp2);
        dpa[1] <= dpa[0];
        dpb[0] <= ip(b_dp_inp1, b_dp_inp2);
        dpb[1] <= dpb[0];
        dpb[2] <= dpb[1];
    end
    assign dp_outp   = dpa[1];
    assign b_dp_outp = dpb[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
        b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_resp_ready = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = '1;
        b_req_valid = '1;
        #2;
        checks++;
        if (req_ready !== '0 || b_req_ready !== '0) begin
            errors++; $display("FAIL reset_req_ready got %b/%b exp 0000", req_ready, b_req_ready);
        end
        checks++;
        if (resp_valid !== '0 || resp_data !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_resp got v=%b d=%h busy=%b exp 0", resp_valid, resp_data, busy);
        end
        checks++;
        if (dp_inp1 !== '0 || dp_inp2 !== '0) begin
            errors++; $display("FAIL reset_dp got %o/%o exp 0/0", dp_inp1, dp_inp2);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [8:0] e_inp1;
        do_reset();
        req_a[8:0] = 9'o321;
        req_b[8:0] = 9'o654;
        req_valid  = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL single_ready c=%0d got %b", c, req_ready);
            end
            e_inp1 = (c == 1) ? 9'o321 : 9'o000;
            checks++;
            if (dp_inp1 !== e_inp1 || (c == 1 && dp_inp2 !== 9'o654)) begin
                errors++; $display("FAIL single_dp c=%0d got %o/%o exp %o", c, dp_inp1, dp_inp2, e_inp1);
            end
            checks++;
            if (resp_valid !== ((c == 4) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL single_valid c=%0d got %b", c, resp_valid);
            end
            if (c == 4) begin
                checks++;
                if (resp_data[7:0] !== 8'd32) begin
                    errors++; $display("FAIL single_data got %0d exp 32", resp_data[7:0]);
                end
            end
            checks++;
            if (busy !== (c >= 1 && c <= 4)) begin
                errors++; $display("FAIL single_busy c=%0d got %b", c, busy);
            end
            tick();
            req_valid = '0;
        end
    endtask

    task automatic test_all4();
        logic [N-1:0] e_rdy, e_v;
        do_reset();
        req_a = {N{9'o777}};
        req_b = {N{9'o777}};
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            e_rdy = '0;
            e_v = '0;
            if (c < 4) e_rdy[c] = 1'b1;
            if (c >= 4 && c < 8) e_v[c-4] = 1'b1;
            @(negedge clk);
            checks++;
            if (req_ready !== e_rdy) begin
                errors++; $display("FAIL all4_ready c=%0d got %b exp %b", c, req_ready, e_rdy);
            end
            checks++;
            if (resp_valid !== e_v) begin
                errors++; $display("FAIL all4_valid c=%0d got %b exp %b", c, resp_valid, e_v);
            end
            if (c >= 4 && c < 8) begin
                checks++;
                if (resp_data[8*(c-4) +: 8] !== 8'd147) begin
                    errors++; $display("FAIL all4_data c=%0d got %0d exp 147", c, resp_data[8*(c-4) +: 8]);
                end
            end
            checks++;
            if (busy !== (c >= 1 && c <= 7)) begin
                errors++; $display("FAIL all4_busy c=%0d got %b", c, busy);
            end
            tick();
            req_valid = req_valid & ~e_rdy;
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] e_rdy, e_v;
        do_reset();
        req_valid = 4'b0101;
        for (int c = 0; c < 16; c++) begin
            e_rdy = (c % 5 == 0) ? 4'b0001 : (c % 5 == 1) ? 4'b0100 : 4'b0000;
            e_v = '0;
            e_v[0] = (c >= 4) && (c % 5 == 4);
            e_v[2] = (c >= 5) && (c % 5 == 0);
            @(negedge clk);
            checks++;
            if (req_ready !== e_rdy) begin
                errors++; $display("FAIL fair_ready c=%0d got %b exp %b", c, req_ready, e_rdy);
            end
            checks++;
            if (resp_valid !== e_v) begin
                errors++; $display("FAIL fair_valid c=%0d got %b exp %b", c, resp_valid, e_v);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] e_rdy, e_v;
        logic [7:0] r0_exp, r1_exp, r3_exp;
        do_reset();
        req_a = 36'({$urandom(), $urandom()});
        req_b = 36'({$urandom(), $urandom()});
        req_a[17:9] = 9'o735;
        req_b[17:9] = 9'o246;
        r0_exp = ip(req_a[8:0], req_b[8:0]);
        r1_exp = ip(9'o735, 9'o246);
        r3_exp = ip(req_a[35:27], req_b[35:27]);
        resp_ready = 4'b1101;
        req_valid  = 4'b0010;
        for (int c = 0; c < 17; c++) begin
            if (c == 5)  req_valid = req_valid | 4'b1001;
            if (c == 6)  req_valid[3] = 1'b0;
            if (c == 7)  req_valid[0] = 1'b0;
            if (c == 14) resp_ready = '1;
            e_rdy = (c == 0 || c == 15) ? 4'b0010 : (c == 5) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'b0000;
            e_v = {c == 9, 1'b0, c >= 4 && c <= 14, c == 10};
            @(negedge clk);
            checks++;
            if (req_ready !== e_rdy) begin
                errors++; $display("FAIL bp_ready c=%0d got %b exp %b", c, req_ready, e_rdy);
            end
            checks++;
            if (resp_valid !== e_v) begin
                errors++; $display("FAIL bp_valid c=%0d got %b exp %b", c, resp_valid, e_v);
            end
            if (e_v[1]) begin
                checks++;
                if (resp_data[15:8] !== r1_exp) begin
                    errors++; $display("FAIL bp_hold_data c=%0d got %0d exp %0d", c, resp_data[15:8], r1_exp);
                end
            end
            if (c == 9 || c == 10) begin
                checks++;
                if (resp_data[31:24] !== r3_exp || (c == 10 && resp_data[7:0] !== r0_exp)) begin
                    errors++; $display("FAIL bp_other_data c=%0d got %0d/%0d exp %0d/%0d",
                                       c, resp_data[31:24], resp_data[7:0], r3_exp, r0_exp);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_midflight_reset();
        do_reset();
        req_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL mid_grant0 got %b exp 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_grant1 got %b exp 0010", req_ready);
        end
        tick();
        req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || resp_data !== '0 ||
            dp_inp1 !== '0 || dp_inp2 !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_async_clear got rdy=%b v=%b d=%h dp=%o/%o busy=%b exp all 0",
                               req_ready, resp_valid, resp_data, dp_inp1, dp_inp2, busy);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        req_valid = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== '0) begin
                errors++; $display("FAIL mid_no_resp c=%0d got %b exp 0000", c, resp_valid);
            end
            tick();
        end
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_rr_restart got %b exp 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL mid_r3_grant got %b exp 1000", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_lat3();
        do_reset();
        b_req_a[8:0] = 9'o111;
        b_req_b[8:0] = 9'o222;
        b_req_valid  = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (b_req_ready !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL lat3_ready c=%0d got %b", c, b_req_ready);
            end
            checks++;
            if (b_resp_valid !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL lat3_valid c=%0d got %b", c, b_resp_valid);
            end
            if (c == 5) begin
                checks++;
                if (b_resp_data[7:0] !== 8'd6) begin
                    errors++; $display("FAIL lat3_data got %0d exp 6", b_resp_data[7:0]);
                end
            end
            tick();
            b_req_valid = '0;
        end
    endtask

    // Model: each requester is free or owes one result that appears LAT+2 cycles after accept.
    task automatic test_random();
        bit         mfree [N];
        int         mdone [N];
        logic [7:0] mdata [N];
        int mptr, g, idx, cyc, accepts, completed, observed;
        logic [N-1:0] e_rdy;
        bit ev, outstanding;
        do_reset();
        for (int i = 0; i < N; i++) begin
            mfree[i] = 1'b1; mdone[i] = 0; mdata[i] = '0;
        end
        mptr = 0; cyc = 0; accepts = 0; completed = 0; observed = 0;
        outstanding = 1'b0;
        while (cyc < 20000 && (accepts < 2000 || outstanding)) begin
            b_req_valid = (accepts < 2000) ? 4'($urandom()) : 4'b0000;
            b_req_a = 36'({$urandom(), $urandom()});
            b_req_b = 36'({$urandom(), $urandom()});
            for (int i = 0; i < N; i++) b_resp_ready[i] = ($urandom_range(3) != 0);
            @(negedge clk);
            g = -1;
            for (int off = 0; off < N; off++) begin
                idx = (mptr + off) % N;
                if (g < 0 && b_req_valid[idx] && mfree[idx]) g = idx;
            end
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            checks++;
            if (b_req_ready !== e_rdy) begin
                errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, b_req_ready, e_rdy);
            end
            for (int i = 0; i < N; i++) begin
                ev = !mfree[i] && cyc >= mdone[i];
                checks++;
                if (b_resp_valid[i] !== ev) begin
                    errors++; $display("FAIL rand_valid cyc=%0d req=%0d got %b exp %b", cyc, i, b_resp_valid[i], ev);
                end
                if (ev) begin
                    checks++;
                    if (b_resp_data[8*i +: 8] !== mdata[i]) begin
                        errors++; $display("FAIL rand_data cyc=%0d req=%0d got %0d exp %0d",
                                           cyc, i, b_resp_data[8*i +: 8], mdata[i]);
                    end
                    if (b_resp_ready[i]) begin
                        mfree[i] = 1'b1;
                        completed++;
                    end
                end
                if (b_resp_valid[i] && b_resp_ready[i]) observed++;
            end
            if (g >= 0) begin
                mfree[g] = 1'b0;
                mdone[g] = cyc + 3 + 2;
                mdata[g] = ip(b_req_a[9*g +: 9], b_req_b[9*g +: 9]);
                mptr = (g + 1) % N;
                accepts++;
            end
            outstanding = 1'b0;
            for (int i = 0; i < N; i++) if (!mfree[i]) outstanding = 1'b1;
            tick();
            cyc++;
        end
        b_req_valid = '0;
        b_resp_ready = '1;
        checks++;
        if (accepts < 2000 || outstanding) begin
            errors++; $display("FAIL rand_budget accepts=%0d outstanding=%b exp 2000/0", accepts, outstanding);
        end
        checks++;
        if (observed !== accepts || completed !== accepts) begin
            errors++; $display("FAIL rand_count got %0d results exp %0d (model %0d)", observed, accepts, completed);
        end
    endtask

    initial begin
        idle_inputs();
        #7;
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_backpressure();
        test_midflight_reset();
        test_lat3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
